// File: rtl/argmax_reader.sv
// argmax_reader: sequentially reads the logit RAM and reports the index/value of the largest signed logit.
// Define ARGMAX_MARGIN_EN to also track the runner-up and output the top1-top2 margin.
module argmax_reader #(
    parameter int OUT_DIM = 10,
    parameter int IDX_W = $clog2(OUT_DIM)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic [IDX_W-1:0]        y_addr,
    input  logic signed [31:0]      y_data,
    output logic [IDX_W-1:0]        class_idx,
    output logic signed [31:0]      max_logit,
    output logic                    result_valid
`ifdef ARGMAX_MARGIN_EN
    ,
    output logic [32:0]             margin
`endif
);
    typedef enum logic [1:0] {S_IDLE, S_PRIME, S_SCAN} state_t;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(OUT_DIM - 1);
    state_t state, state_nx;
    logic busy_nx, done_nx, rv_nx, first, gt;
    logic [IDX_W-1:0] addr_nx, rd_idx, rd_nx, best_idx, best_idx_nx, cls_nx, cand_idx;
    logic signed [31:0] best, best_nx, max_nx, cand;
    assign first    = rd_idx == '0;
    assign gt       = y_data > best;
    assign cand     = (first || gt) ? y_data : best;
    assign cand_idx = first ? '0 : gt ? rd_idx : best_idx;
`ifdef ARGMAX_MARGIN_EN
    logic signed [31:0] best2, best2_nx, cand2;
    logic [32:0] margin_nx;
    // A later tie with the leader becomes the runner-up, so equal top values give a zero margin.
    assign cand2 = first ? 32'sh8000_0000 : gt ? best :
                   (y_data > best2 || y_data == best) ? y_data : best2;
`endif
    always_comb begin
        state_nx    = state;
        busy_nx     = busy;
        done_nx     = 1'b0;
        rv_nx       = result_valid;
        addr_nx     = y_addr;
        rd_nx       = rd_idx;
        best_nx     = best;
        best_idx_nx = best_idx;
        cls_nx      = class_idx;
        max_nx      = max_logit;
`ifdef ARGMAX_MARGIN_EN
        best2_nx    = best2;
        margin_nx   = margin;
`endif
        case (state)
            S_IDLE: if (start) begin
                addr_nx  = '0;
                busy_nx  = 1'b1;
                rv_nx    = 1'b0;
                state_nx = S_PRIME;
            end
            S_PRIME: begin
                addr_nx  = IDX_W'(1);
                rd_nx    = '0;
                state_nx = S_SCAN;
            end
            S_SCAN: begin
                best_nx     = cand;
                best_idx_nx = cand_idx;
`ifdef ARGMAX_MARGIN_EN
                best2_nx    = cand2;
`endif
                addr_nx     = (y_addr == LAST) ? y_addr : y_addr + 1'b1;
                if (rd_idx == LAST) begin
                    cls_nx   = cand_idx;
                    max_nx   = cand;
`ifdef ARGMAX_MARGIN_EN
                    margin_nx = {cand[31], cand} - {cand2[31], cand2};
`endif
                    done_nx  = 1'b1;
                    rv_nx    = 1'b1;
                    busy_nx  = 1'b0;
                    state_nx = S_IDLE;
                end else begin
                    rd_nx = rd_idx + 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            result_valid <= 1'b0;
            y_addr       <= '0;
            rd_idx       <= '0;
            best         <= '0;
            best_idx     <= '0;
            class_idx    <= '0;
            max_logit    <= '0;
`ifdef ARGMAX_MARGIN_EN
            best2        <= '0;
            margin       <= '0;
`endif
        end else begin
            state        <= state_nx;
            busy         <= busy_nx;
            done         <= done_nx;
            result_valid <= rv_nx;
            y_addr       <= addr_nx;
            rd_idx       <= rd_nx;
            best         <= best_nx;
            best_idx     <= best_idx_nx;
            class_idx    <= cls_nx;
            max_logit    <= max_nx;
`ifdef ARGMAX_MARGIN_EN
            best2        <= best2_nx;
            margin       <= margin_nx;
`endif
        end
    end
endmodule

// File: tb/tb_argmax_reader.sv
// tb_argmax_reader: directed checks of scan timing, signed argmax, tie handling, start filtering and reset abort.
module tb_argmax_reader;
    localparam int N = 10;
    localparam int W = $clog2(N);
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic busy, done, result_valid;
    logic [W-1:0] y_addr, class_idx;
    logic signed [31:0] y_data, max_logit;
`ifdef ARGMAX_MARGIN_EN
    logic [32:0] margin;
`endif
    logic signed [31:0] mem [N];
    int checks = 0, failures = 0;

    argmax_reader #(.OUT_DIM(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .y_addr(y_addr), .y_data(y_data), .class_idx(class_idx),
        .max_logit(max_logit), .result_valid(result_valid)
`ifdef ARGMAX_MARGIN_EN
        , .margin(margin)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) y_data <= mem[y_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (done === 1'b1) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({busy, done, y_addr, class_idx, max_logit, result_valid} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got busy=%b done=%b addr=%0d cls=%0d max=%0d rv=%b exp all 0",
                     busy, done, y_addr, class_idx, max_logit, result_valid);
        end
`ifdef ARGMAX_MARGIN_EN
        checks++;
        if (margin !== 33'd0) begin failures++; $display("FAIL reset_margin got=%h exp=0", margin); end
`endif
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_tie();
        int cyc;
        mem = '{-5, 3, 7, 2, 0, -1, 6, 7, 1, -9};
        do_start();
        checks++;
        if (busy !== 1'b1 || result_valid !== 1'b0) begin
            failures++; $display("FAIL basic_accept got busy=%b rv=%b exp busy=1 rv=0", busy, result_valid);
        end
        wait_done(cyc);
        checks++;
        if (cyc !== 11) begin failures++; $display("FAIL basic_latency got=%0d exp=11", cyc); end
        checks++;
        if (class_idx !== 4'd2 || max_logit !== 32'sd7) begin
            failures++; $display("FAIL basic_result got cls=%0d max=%0d exp cls=2 max=7", class_idx, max_logit);
        end
        checks++;
        if (result_valid !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL basic_flags got rv=%b busy=%b exp rv=1 busy=0", result_valid, busy);
        end
`ifdef ARGMAX_MARGIN_EN
        checks++;
        if (margin !== 33'd0) begin failures++; $display("FAIL basic_margin got=%h exp=0", margin); end
`endif
        tick();
        checks++;
        if (done !== 1'b0 || class_idx !== 4'd2 || result_valid !== 1'b1) begin
            failures++; $display("FAIL basic_hold got done=%b cls=%0d rv=%b exp done=0 cls=2 rv=1", done, class_idx, result_valid);
        end
    endtask

    task automatic test_min_values();
        int cyc;
        for (int i = 0; i < N; i++) mem[i] = 32'sh8000_0000;
        mem[9] = 32'sh8000_0001;
        do_start();
        wait_done(cyc);
        checks++;
        if (cyc !== 11 || class_idx !== 4'd9 || max_logit !== 32'sh8000_0001) begin
            failures++; $display("FAIL min_result got cyc=%0d cls=%0d max=%0d exp cyc=11 cls=9 max=-2147483647", cyc, class_idx, max_logit);
        end
`ifdef ARGMAX_MARGIN_EN
        checks++;
        if (margin !== 33'd1) begin failures++; $display("FAIL min_margin got=%h exp=1", margin); end
`endif
    endtask

    task automatic test_extremes_addr();
        int bad = 0;
        int done_at = -1;
        for (int i = 0; i < N; i++) mem[i] = 0;
        mem[0] = 32'sh7FFF_FFFF;
        mem[1] = 32'sh8000_0000;
        do_start();
        if (y_addr !== 4'd0) bad++;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (y_addr !== W'(k < 9 ? k : 9)) bad++;
            if (done === 1'b1 && done_at < 0) done_at = k;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL addr_trace got %0d bad samples exp 0", bad); end
        checks++;
        if (done_at !== 11 || class_idx !== 4'd0 || max_logit !== 32'sh7FFF_FFFF) begin
            failures++; $display("FAIL extreme_result got done_at=%0d cls=%0d max=%h exp 11/0/7fffffff", done_at, class_idx, max_logit);
        end
`ifdef ARGMAX_MARGIN_EN
        checks++;
        if (margin !== 33'h0_7FFF_FFFF) begin failures++; $display("FAIL extreme_margin got=%h exp=07fffffff", margin); end
`endif
    endtask

    task automatic test_start_ignored();
        int busy_low = 0, dones = 0, late_busy = 0, done_at = -1;
        mem = '{1, 2, 3, 4, 5, 90, 6, 7, 8, 9};
        do_start();
        for (int i = 1; i <= 11; i++) begin
            start = (i == 3 || i == 5 || i == 11);
            tick();
            start = 1'b0;
            if (i < 11 && busy !== 1'b1) busy_low++;
            if (done === 1'b1) begin dones++; done_at = i; end
        end
        for (int i = 0; i < 14; i++) begin
            tick();
            if (done === 1'b1) dones++;
            if (busy === 1'b1) late_busy++;
        end
        checks++;
        if (busy_low != 0) begin failures++; $display("FAIL ignore_busy got %0d low cycles exp 0", busy_low); end
        checks++;
        if (dones != 1 || done_at != 11) begin failures++; $display("FAIL ignore_done got count=%0d at=%0d exp 1 at 11", dones, done_at); end
        checks++;
        if (late_busy != 0 || class_idx !== 4'd5) begin
            failures++; $display("FAIL ignore_rescan got busy_cycles=%0d cls=%0d exp 0/5", late_busy, class_idx);
        end
    endtask

    task automatic test_reset_mid();
        int cyc, dones = 0;
        mem = '{-5, 3, 7, 2, 0, -1, 6, 7, 1, -9};
        do_start();
        for (int i = 1; i <= 5; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if ({busy, done, y_addr, class_idx, max_logit, result_valid} !== '0) begin
            failures++;
            $display("FAIL midreset_outputs got busy=%b done=%b addr=%0d cls=%0d max=%0d rv=%b exp all 0",
                     busy, done, y_addr, class_idx, max_logit, result_valid);
        end
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin failures++; $display("FAIL midreset_quiet got %0d active cycles exp 0", dones); end
        for (int i = 0; i < N; i++) mem[i] = -100;
        mem[4] = 100;
        do_start();
        wait_done(cyc);
        checks++;
        if (cyc !== 11 || class_idx !== 4'd4 || max_logit !== 32'sd100) begin
            failures++; $display("FAIL midreset_rescan got cyc=%0d cls=%0d max=%0d exp 11/4/100", cyc, class_idx, max_logit);
        end
`ifdef ARGMAX_MARGIN_EN
        checks++;
        if (margin !== 33'd200) begin failures++; $display("FAIL midreset_margin got=%0d exp=200", margin); end
`endif
    endtask

    task automatic test_back_to_back();
        int d_at [3];
        logic [W-1:0] d_cls [3];
        int nd = 0, rv_low = 0;
        logic rv23 = 1'b0;
        mem = '{-5, 3, 7, 2, 0, -1, 6, 7, 1, -9};
        start = 1'b1;
        tick();
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (done === 1'b1) begin
                if (nd < 3) begin d_at[nd] = i; d_cls[nd] = class_idx; end
                nd++;
            end
            if (i == 11) mem[8] = 50;
            if (i == 23) mem[1] = 60;
            if (i >= 12 && i <= 22 && result_valid === 1'b0) rv_low++;
            if (i == 23) rv23 = result_valid;
        end
        start = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        checks++;
        if (nd != 3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", nd); end
        else begin
            checks++;
            if (d_at[0] != 11 || d_at[1] != 23 || d_at[2] != 35) begin
                failures++; $display("FAIL b2b_spacing got %0d,%0d,%0d exp 11,23,35", d_at[0], d_at[1], d_at[2]);
            end
            checks++;
            if (d_cls[0] !== 4'd2 || d_cls[1] !== 4'd8 || d_cls[2] !== 4'd1) begin
                failures++; $display("FAIL b2b_class got %0d,%0d,%0d exp 2,8,1", d_cls[0], d_cls[1], d_cls[2]);
            end
        end
        checks++;
        if (rv_low != 11 || rv23 !== 1'b1) begin
            failures++; $display("FAIL b2b_valid got low=%0d rv23=%b exp 11/1", rv_low, rv23);
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) mem[i] = 0;
        test_reset();
        test_basic_tie();
        test_min_values();
        test_extremes_addr();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
